uart_tx_configurable: RTL and testbench
=======================================

// Module: uart_tx_configurable
// PURPOSE
//  Parametrised UART transmitter: serialises one word per valid/ready handshake into a framed line.
//  Frame is start, data LSB-first, optional parity, then 1 or 2 stop bits.
//  Adds back-to-back framing, done/busy status and configurable format/baud.
//  Sits between a byte-producing client (FIFO, debug port) and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200); legal >= 2
//  DATA_BITS     8    data bits per frame; legal 5..9
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    stop bits per frame; legal 1 or 2
// PORTS
//  clk         in   1          system clock, all logic on posedge
//  i_reset_n   in   1          asynchronous active-low reset
//  i_data      in   DATA_BITS  word to send; sampled only on handshake
//  i_valid     in   1          client has a word on i_data
//  o_ready     out  1          block accepts a word this cycle
//  o_tx        out  1          serial line, idles high, registered output
//  o_busy      out  1          frame in progress (any state but IDLE)
//  o_done      out  1          one-cycle pulse after the final stop bit completes
// BEHAVIOUR
//  Reset (async assert, sync release): o_tx=1, o_busy=0, o_done=0, o_ready=1.
//  - All counters are cleared and state is IDLE.
//  Handshake: a word is accepted on a posedge where i_valid && o_ready.
//  - The word is copied to an internal shift register; i_data is don't-care afterwards.
//  - i_valid while o_ready=0 is ignored, with no queueing.
//  - i_valid may be held high; each accept consumes exactly one word.
//  o_ready=1 in IDLE and in the last cycle of the last stop bit; 0 otherwise.
//  States:
//  - IDLE -> START on accept.
//  - START -> DATA after CLKS_PER_BIT cycles.
//  - DATA -> PARITY after DATA_BITS bits, or -> STOP if PARITY=0.
//  - PARITY -> STOP.
//  - STOP -> IDLE after STOP_BITS bits, or -> START if an accept occurred in its last cycle.
//  Latency: o_tx drives 0 starting the cycle after the accept edge.
//  Bit timing: every bit, including stop bits, holds o_tx for exactly CLKS_PER_BIT cycles.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
//  Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0 at the bit boundary.
//  Bit index counter: counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP, cleared on each state change.
//  Parity is computed on the captured word, not on live i_data.
//  - Odd: data ones + parity bit is odd.
//  - Even: data ones + parity bit is even.
//  o_busy=1 from the cycle after accept through the last stop cycle.
//  - With back-to-back frames o_busy never drops between them.
//  o_done is registered and high for exactly one cycle per completed frame.
//  - It coincides with the first idle cycle, or the first START cycle when frames are back-to-back.
//  Reset mid-frame: o_tx returns to 1 asynchronously and the frame is discarded.
//  - No o_done is issued; o_ready=1 on release.
//  o_tx is never X or glitching: driven from a flop, 1 in all non-frame cycles.
// TESTING (bench uses CLKS_PER_BIT=4)
//  1. Defaults, send 8'hA5 -> per 4 cycles o_tx = 0,1,0,1,0,0,1,0,1,1.
//     - 40-cycle frame; o_done one pulse; o_ready back to 1 at cycle 40.
//  2. PARITY=2, send 8'h07 -> parity bit 1; PARITY=1, send 8'h07 -> parity bit 0.
//     - Frame is 44 cycles in both cases.
//  3. i_valid held high with 8'h00 then 8'hFF -> two contiguous 40-cycle frames, no idle gap.
//     - o_busy stays 1 throughout; o_done pulses twice, 40 cycles apart.
//  4. i_valid pulsed with 8'h3C during frame of 8'hA5 -> ignored.
//     - Only the 8'hA5 frame appears; i_data changed after accept does not alter the line.
//  5. i_reset_n low during data bit 3 -> o_tx=1 immediately, o_busy=0, no o_done.
//     - After release, send 8'h81 -> correct 40-cycle frame.
//  6. DATA_BITS=7, STOP_BITS=2, PARITY=0, send 7'h55 -> 0,1,0,1,0,1,0,1,1,1.
//     - 40-cycle frame; o_ready high only in the final cycle of stop bit 2.

Source files
------------

// File: rtl/uart_tx_configurable.sv
// UART transmitter: accepts one word per valid/ready handshake and frames it as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_configurable #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end, stop_last, accept;

  // Odd parity inverts the XOR-reduction so data ones plus parity is odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY == 1);
  endfunction

  assign bit_end   = (baud_q == BAUD_LAST);
  assign stop_last = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
  assign o_ready   = (state_q == S_IDLE) || stop_last;
  assign accept    = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = stop_last;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // A handshake in IDLE or in the final stop cycle starts the next frame directly.
    if (accept) begin
      state_d = S_START;
      baud_d  = '0;
      idx_d   = '0;
      shift_d = i_data;
      par_d   = parity_bit(i_data);
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Bench for uart_tx_configurable: four format variants driven with directed and
// random words; expected frames are queued at issue time and checked each cycle.
module tb_uart_tx_configurable;

  localparam int C = 4;

  typedef struct {
    int          start;
    int          len;
    logic [15:0] bits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] data [4];
  logic       valid [4];
  logic       tx [4], ready [4], busy [4], done [4];

  int     cyc = 0;
  int     free_at [4] = '{0, 0, 0, 0};
  int     done_at [4] = '{-1, -1, -1, -1};
  int     n_checks = 0;
  int     n_fail = 0;
  frame_t exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_configurable #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .i_reset_n(rst_n), .i_data(data[0][7:0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
  uart_tx_configurable #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .i_reset_n(rst_n), .i_data(data[1][7:0]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
  uart_tx_configurable #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .i_reset_n(rst_n), .i_data(data[2][7:0]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
  uart_tx_configurable #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .i_reset_n(rst_n), .i_data(data[3][6:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

  function automatic int cfg_db(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(input int i);
    if (i == 1) return 2;
    if (i == 2) return 1;
    return 0;
  endfunction

  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Line bits of one frame, index 0 sent first; unused upper bits stay 1 (stop level).
  function automatic frame_t build(input int i, input logic [8:0] w, input int start);
    frame_t f;
    int n;
    int ones;
    f.bits = '1;
    n = 0;
    ones = 0;
    f.bits[n] = 1'b0;
    n++;
    for (int k = 0; k < cfg_db(i); k++) begin
      f.bits[n] = w[k];
      if (w[k]) ones++;
      n++;
    end
    if (cfg_par(i) != 0) begin
      if (cfg_par(i) == 2) f.bits[n] = ((ones % 2) == 1);
      else                 f.bits[n] = ((ones % 2) == 0);
      n++;
    end
    n += cfg_sb(i);
    f.len = n * C;
    f.start = start;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int i, input logic [8:0] w, input bit hold);
    frame_t f;
    int a;
    valid[i] = 1'b1;
    data[i] = w;
    a = (cyc + 1 > free_at[i]) ? cyc + 1 : free_at[i];
    f = build(i, w, a);
    exp_q[i].push_back(f);
    free_at[i] = a + f.len;
    while (cyc < a) tick(1);
    if (!hold) valid[i] = 1'b0;
    data[i] = 9'($urandom);
  endtask

  task automatic pulse_ignored(input int i, input logic [8:0] w);
    valid[i] = 1'b1;
    data[i] = w;
    tick(1);
    valid[i] = 1'b0;
    data[i] = 9'($urandom);
  endtask

  task automatic wait_free(input int i);
    while (cyc < free_at[i]) tick(1);
  endtask

  task automatic rand_run(input int i);
    int gap;
    int next_gap;
    next_gap = $urandom_range(0, 3);
    for (int n = 0; n < 12; n++) begin
      gap = next_gap;
      next_gap = $urandom_range(0, 3);
      send(i, 9'($urandom), (next_gap == 0) && (n != 11));
      if (next_gap == 3) pulse_ignored(i, 9'($urandom));
      if (next_gap > 0) begin
        wait_free(i);
        tick(next_gap - 1);
      end
    end
    wait_free(i);
  endtask

  // Monitor: retire finished frames, then compare the whole output vector.
  logic [3:0] m_exp, m_act;
  int         m_j;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      while (exp_q[i].size() > 0 && cyc >= exp_q[i][0].start + exp_q[i][0].len) begin
        done_at[i] = exp_q[i][0].start + exp_q[i][0].len;
        void'(exp_q[i].pop_front());
      end
      m_exp = {1'b1, 1'b0, 1'b1, (cyc == done_at[i])};
      if (exp_q[i].size() > 0 && cyc >= exp_q[i][0].start) begin
        m_j = cyc - exp_q[i][0].start;
        m_exp[3] = exp_q[i][0].bits[m_j / C];
        m_exp[2] = 1'b1;
        m_exp[1] = (m_j == exp_q[i][0].len - 1);
      end
      m_act = {tx[i], busy[i], ready[i], done[i]};
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL line%0d cyc=%0d tx/busy/ready/done got %b want %b", i, cyc, m_act, m_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i] = '0;
    end
    tick(3);
    rst_n = 1'b1;

    // Plain frame with an ignored mid-frame request and post-accept data churn.
    send(0, 9'h0A5, 1'b0);
    tick(10);
    pulse_ignored(0, 9'h03C);
    wait_free(0);
    tick(3);

    // Parity variants and the 7-bit / 2-stop format in parallel.
    send(1, 9'h007, 1'b0);
    send(2, 9'h007, 1'b0);
    send(3, 9'h055, 1'b0);
    // Back-to-back frames with valid held high.
    send(0, 9'h000, 1'b1);
    send(0, 9'h0FF, 1'b0);
    for (int i = 0; i < 4; i++) wait_free(i);
    tick(3);

    // Reset during data bit 3, then a clean frame.
    send(0, 9'h05A, 1'b0);
    a = cyc;
    tick(17);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      free_at[i] = 0;
      done_at[i] = -1;
    end
    #1;
    n_checks++;
    if (tx[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx got %b want 1 (frame start cyc %0d)", tx[0], a);
    end
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy[0]);
    end
    tick(2);
    rst_n = 1'b1;
    send(0, 9'h081, 1'b0);
    wait_free(0);
    tick(3);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
